// File: rtl/i2c_cond_pkg.sv
// Shared definitions for the I2C pad conditioner.
// Holds the bus-state encoding and the default filter / stretch limits.
package i2c_cond_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_t;

    localparam int FILT_LEN_DEF    = 4;
    localparam int STRETCH_LIM_DEF = 8;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchronizer followed by a stability glitch filter.
// Ports: clk, rstn (sync, active-low), raw (async line), level (filtered).
module i2c_glitch_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic level
);

    localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

    logic       sync1;
    logic       sync2;
    logic [3:0] cnt;

    // The level flips on the FILT_LEN-th consecutive cycle that the
    // synchronized input disagrees with it; any agreement restarts the run.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_pad_conditioner.sv
// I2C pad conditioner: open-drain pad drive, line filtering, START/STOP
// detection, bus-busy tracking, arbitration-loss and clock-stretch flags.
// Ports: i_CLK/i_RSTN, MPR121_* pad side, i_* core requests, o_* status.
module i2c_pad_conditioner
    import i2c_cond_pkg::*;
#(
    parameter int FILT_LEN    = FILT_LEN_DEF,
    parameter int STRETCH_LIM = STRETCH_LIM_DEF
) (
    input  logic i_CLK,
    input  logic i_RSTN,
    input  logic MPR121_SCL_IN,
    input  logic MPR121_SDA_IN,
    output logic MPR121_SCL_OUT,
    output logic MPR121_SDA_OUT,
    output logic MPR121_SCL_EN,
    output logic MPR121_SDA_EN,
    input  logic i_scl_drive_low,
    input  logic i_sda_drive_low,
    input  logic i_arb_clr,
    output logic o_scl,
    output logic o_sda,
    output logic o_start,
    output logic o_stop,
    output logic o_busy,
    output logic o_arb_lost,
    output logic o_stretch
);

    // Cycles after reset release during which the filters may still be
    // moving from their forced-high reset value to the real line level.
    localparam logic [4:0] SETTLE   = 5'(FILT_LEN + 3);
    localparam logic [7:0] SLIM     = 8'(STRETCH_LIM);

    bus_state_t state;
    logic       scl_prev;
    logic       sda_prev;
    logic [4:0] settle_cnt;
    logic       settled;
    logic [7:0] stretch_cnt;
    logic       start_det;
    logic       stop_det;
    logic       arb_set;

    assign MPR121_SCL_OUT = 1'b0;
    assign MPR121_SDA_OUT = 1'b0;

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk   (i_CLK),
        .rstn  (i_RSTN),
        .raw   (MPR121_SCL_IN),
        .level (o_scl)
    );

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk   (i_CLK),
        .rstn  (i_RSTN),
        .raw   (MPR121_SDA_IN),
        .level (o_sda)
    );

    assign settled = (settle_cnt == SETTLE);

    // Requiring SCL high in both cycles rejects simultaneous SCL/SDA moves.
    assign start_det = scl_prev & o_scl & sda_prev & ~o_sda;
    assign stop_det  = scl_prev & o_scl & ~sda_prev & o_sda;
    assign arb_set   = ~scl_prev & o_scl & ~i_sda_drive_low & ~o_sda;

    assign o_busy    = (state == BUSY);
    assign o_stretch = (stretch_cnt == SLIM);

    always_ff @(posedge i_CLK) begin
        if (!i_RSTN) begin
            MPR121_SCL_EN <= 1'b0;
            MPR121_SDA_EN <= 1'b0;
            scl_prev      <= 1'b1;
            sda_prev      <= 1'b1;
            settle_cnt    <= '0;
            o_start       <= 1'b0;
            o_stop        <= 1'b0;
            state         <= IDLE;
            o_arb_lost    <= 1'b0;
            stretch_cnt   <= '0;
        end else begin
            MPR121_SCL_EN <= i_scl_drive_low;
            MPR121_SDA_EN <= i_sda_drive_low;
            scl_prev      <= o_scl;
            sda_prev      <= o_sda;

            if (!settled) begin
                settle_cnt <= settle_cnt + 5'd1;
            end

            o_start <= settled & start_det;
            o_stop  <= settled & stop_det;

            case (state)
                IDLE:    if (o_start) state <= BUSY;
                BUSY:    if (o_stop)  state <= IDLE;
                default: state <= IDLE;
            endcase

            if (arb_set) begin
                o_arb_lost <= 1'b1;
            end else if (i_arb_clr) begin
                o_arb_lost <= 1'b0;
            end

            if (i_scl_drive_low || o_scl) begin
                stretch_cnt <= '0;
            end else if (stretch_cnt != SLIM) begin
                stretch_cnt <= stretch_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_pad_conditioner.sv
// Directed self-checking bench for i2c_pad_conditioner (default params).
// Drives raw pad levels / core requests and checks flags at fixed cycles.
module tb_i2c_pad_conditioner;

    logic clk = 1'b0;
    logic rstn;
    logic scl_in, sda_in;
    logic scl_out, sda_out, scl_en, sda_en;
    logic scl_dl, sda_dl, arb_clr;
    logic scl, sda, start, stop, busy, arb_lost, stretch;

    int n_cmp = 0;
    int n_err = 0;
    int n_start = 0;
    int n_stop = 0;
    int b_start, b_stop;

    always #5 clk = ~clk;

    i2c_pad_conditioner dut (
        .i_CLK          (clk),
        .i_RSTN         (rstn),
        .MPR121_SCL_IN  (scl_in),
        .MPR121_SDA_IN  (sda_in),
        .MPR121_SCL_OUT (scl_out),
        .MPR121_SDA_OUT (sda_out),
        .MPR121_SCL_EN  (scl_en),
        .MPR121_SDA_EN  (sda_en),
        .i_scl_drive_low(scl_dl),
        .i_sda_drive_low(sda_dl),
        .i_arb_clr      (arb_clr),
        .o_scl          (scl),
        .o_sda          (sda),
        .o_start        (start),
        .o_stop         (stop),
        .o_busy         (busy),
        .o_arb_lost     (arb_lost),
        .o_stretch      (stretch)
    );

    always @(negedge clk) begin
        if (start === 1'b1) n_start++;
        if (stop === 1'b1) n_stop++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_scl"}, 32'(scl), 32'd1);
        check({tag, "_sda"}, 32'(sda), 32'd1);
        check({tag, "_start"}, 32'(start), 32'd0);
        check({tag, "_stop"}, 32'(stop), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_arb"}, 32'(arb_lost), 32'd0);
        check({tag, "_stretch"}, 32'(stretch), 32'd0);
        check({tag, "_scl_en"}, 32'(scl_en), 32'd0);
        check({tag, "_sda_en"}, 32'(sda_en), 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        scl_in = 1'b1;
        sda_in = 1'b1;
        scl_dl = 1'b0;
        sda_dl = 1'b0;
        arb_clr = 1'b0;

        // Reset state
        step(2);
        check_reset_state("rst");
        check("rst_scl_out", 32'(scl_out), 32'd0);
        check("rst_sda_out", 32'(sda_out), 32'd0);
        rstn = 1'b1;
        step(10);

        // Pad enable is a 1-cycle registered copy of the request
        scl_dl = 1'b1;
        step(1);
        check("en_on", 32'(scl_en), 32'd1);
        scl_dl = 1'b0;
        step(1);
        check("en_off", 32'(scl_en), 32'd0);

        // 3-cycle SCL glitch never reaches o_scl
        b_start = n_start;
        b_stop = n_stop;
        scl_in = 1'b0;
        step(3);
        scl_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            check("glitch_scl", 32'(scl), 32'd1);
        end
        check("glitch_nstart", 32'(n_start - b_start), 32'd0);
        check("glitch_nstop", 32'(n_stop - b_stop), 32'd0);

        // START: filtered at +6, o_start at +7, busy at +8
        b_start = n_start;
        b_stop = n_stop;
        sda_dl = 1'b1;
        sda_in = 1'b0;
        step(5);
        check("start_sda_p5", 32'(sda), 32'd1);
        step(1);
        check("start_sda_p6", 32'(sda), 32'd0);
        check("start_p6", 32'(start), 32'd0);
        step(1);
        check("start_p7", 32'(start), 32'd1);
        check("start_busy_p7", 32'(busy), 32'd0);
        step(1);
        check("start_p8", 32'(start), 32'd0);
        check("start_busy_p8", 32'(busy), 32'd1);
        check("start_sda_en", 32'(sda_en), 32'd1);

        // 9 SCL clocks then STOP
        for (int i = 0; i < 9; i++) begin
            scl_in = 1'b0;
            step(8);
            scl_in = 1'b1;
            step(8);
        end
        check("xfer_busy", 32'(busy), 32'd1);
        sda_in = 1'b1;
        step(6);
        check("stop_p6", 32'(stop), 32'd0);
        step(1);
        check("stop_p7", 32'(stop), 32'd1);
        check("stop_busy_p7", 32'(busy), 32'd1);
        step(1);
        check("stop_p8", 32'(stop), 32'd0);
        check("stop_busy_p8", 32'(busy), 32'd0);
        check("xfer_nstart", 32'(n_start - b_start), 32'd1);
        check("xfer_nstop", 32'(n_stop - b_stop), 32'd1);
        check("xfer_arb", 32'(arb_lost), 32'd0);
        sda_dl = 1'b0;

        // Arbitration loss on SCL rise with SDA low and not driven
        b_start = n_start;
        b_stop = n_stop;
        scl_in = 1'b0;
        step(8);
        sda_in = 1'b0;
        step(8);
        scl_in = 1'b1;
        step(6);
        check("arb_p6", 32'(arb_lost), 32'd0);
        step(1);
        check("arb_p7", 32'(arb_lost), 32'd1);
        step(5);
        check("arb_hold", 32'(arb_lost), 32'd1);
        check("arb_busy", 32'(busy), 32'd0);
        arb_clr = 1'b1;
        step(1);
        arb_clr = 1'b0;
        check("arb_clr", 32'(arb_lost), 32'd0);
        scl_in = 1'b0;
        step(8);
        scl_in = 1'b1;
        step(6);
        check("arb2_p6", 32'(arb_lost), 32'd0);
        arb_clr = 1'b1;
        step(1);
        arb_clr = 1'b0;
        check("arb_set_wins", 32'(arb_lost), 32'd1);
        step(3);
        check("arb2_hold", 32'(arb_lost), 32'd1);
        arb_clr = 1'b1;
        step(1);
        arb_clr = 1'b0;
        check("arb_clr2", 32'(arb_lost), 32'd0);
        scl_in = 1'b0;
        step(8);
        sda_in = 1'b1;
        step(8);
        scl_in = 1'b1;
        step(8);
        check("arb_nstart", 32'(n_start - b_start), 32'd0);
        check("arb_nstop", 32'(n_stop - b_stop), 32'd0);

        // Clock stretch: target holds SCL low after core release
        scl_dl = 1'b1;
        scl_in = 1'b0;
        step(10);
        check("str_scl_low", 32'(scl), 32'd0);
        check("str_driven", 32'(stretch), 32'd0);
        scl_dl = 1'b0;
        step(7);
        check("str_c7", 32'(stretch), 32'd0);
        step(1);
        check("str_c8", 32'(stretch), 32'd1);
        step(12);
        check("str_sat", 32'(stretch), 32'd1);
        scl_in = 1'b1;
        step(6);
        check("str_rel_scl", 32'(scl), 32'd1);
        check("str_rel_p6", 32'(stretch), 32'd1);
        step(1);
        check("str_rel_p7", 32'(stretch), 32'd0);

        // Reset while BUSY: no STOP, clean state, no false START after
        sda_in = 1'b0;
        step(10);
        check("mid_busy", 32'(busy), 32'd1);
        scl_dl = 1'b1;
        sda_dl = 1'b1;
        step(1);
        check("mid_sda_en", 32'(sda_en), 32'd1);
        b_start = n_start;
        b_stop = n_stop;
        rstn = 1'b0;
        step(1);
        check_reset_state("mid_rst");
        step(2);
        rstn = 1'b1;
        scl_dl = 1'b0;
        sda_dl = 1'b0;
        step(15);
        check("post_sda", 32'(sda), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_nstart", 32'(n_start - b_start), 32'd0);
        check("post_nstop", 32'(n_stop - b_stop), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
